dds_multi_conf_decoder: RTL and testbench
=========================================

Name: dds_multi_conf_decoder

Overview:
- Framed configuration decoder for NUM_CH DDS channels, fed one 32-bit word per conf_valid strobe from the PS-side AXI register path.
- Each frame carries: sync word, header (channel index plus enable), frequency word, phase word, wave word and an XOR checksum.
- A frame commits atomically to the addressed channel's output registers only when its checksum matches. Bad frames, stalled frames and illegal channel indices are discarded and flagged.

Parameters:
- NUM_CH, 4, number of DDS channels (1..16).
- PW, 12, phase word width (1..32).
- FRAME_SYNC, 32'hFFFF_FFFF, frame start word.
- TIMEOUT, 1024, maximum idle cycles between words inside a frame before abort (≥2).

Ports:
- axi_clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- conf_data  in  32  configuration word.
- conf_valid  in  1  one-cycle strobe; conf_data is valid when high.
- dds_work_flag  in  1  global DDS run enable.
- f_word  out  NUM_CH*32  per-channel frequency words; channel k occupies [32k+31:32k].
- p_word  out  NUM_CH*PW  per-channel phase words; channel k occupies [PW*k+PW-1:PW*k].
- wave_type  out  NUM_CH*2  per-channel wave select.
- ch_en  out  NUM_CH  per-channel enable, gated by dds_work_flag.
- cfg_update  out  NUM_CH  one-cycle pulse on the committed channel.
- frame_err  out  1  one-cycle pulse when a frame is discarded.
- err_code  out  2  cause of the last error, held until the next error: 1 = checksum, 2 = bad channel, 3 = timeout.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: f_word, p_word, wave_type, cfg_update, frame_err, err_code all 0; internal en_reg all 0; FSM in IDLE; timeout counter 0.
- Words are consumed only on cycles where conf_valid=1.
- FSM states: IDLE, HDR, FREQ, PHASE, WAVE, CSUM.
  - IDLE: conf_data==FRAME_SYNC → HDR. Any other word is ignored.
  - HDR: latch ch_idx=conf_data[3:0] and en_bit=conf_data[8]. If ch_idx≥NUM_CH: frame_err, err_code=2, go to IDLE. Otherwise go to FREQ.
  - FREQ: latch tmp_f=conf_data → PHASE.
  - PHASE: latch tmp_p=conf_data[PW-1:0] → WAVE.
  - WAVE: latch tmp_w=conf_data[1:0] → CSUM.
  - CSUM: expected value = header XOR freq XOR phase XOR wave, using the full 32-bit words as received.
    - Match: on the next edge write tmp_f/tmp_p/tmp_w into channel ch_idx, set en_reg[ch_idx]=en_bit, pulse cfg_update[ch_idx] for one cycle.
    - Mismatch: frame_err pulse, err_code=1.
    - Either way → IDLE.
- FRAME_SYNC is recognised only in IDLE. Inside a frame, a word equal to FRAME_SYNC is treated as data, so a frequency word of 0xFFFF_FFFF is legal.
- Latency: the commit (or frame_err) appears exactly 1 cycle after the checksum word is accepted.
- Timeout: outside IDLE, the counter increments on each cycle with conf_valid=0 and clears on each accepted word. When it reaches TIMEOUT: frame_err pulse, err_code=3, go to IDLE, counter cleared.
- dds_work_flag:
  - Registered into dds_en, 1-cycle delay.
  - ch_en = en_reg & {NUM_CH{dds_en}}.
  - dds_en=0 while not in IDLE: abort to IDLE with no frame_err and no commit.
  - f/p/wave/en_reg values are retained while dds_en=0.
  - Frames are decoded only while dds_en=1; IDLE ignores all words while dds_en=0.
- Channels not addressed by a frame never change. Only one channel can commit per cycle.
- An async reset mid-frame discards the frame; every output returns to its reset value immediately.

Decomposition:
- Package dds_conf_pkg:
  - FSM state encoding (localparams S_IDLE..S_CSUM, 3 bits).
  - err_code constants ERR_CSUM/ERR_CH/ERR_TO.
  - Header field positions HDR_CH_LSB=0, HDR_CH_W=4, HDR_EN_BIT=8.
- One natural sub-module: dds_ch_regs. It is the per-channel register bank, instantiated NUM_CH times via generate, with ports wr_en, f/p/w in and f/p/w/en out.
- The FSM, checksum and timeout logic stay in the top level.

Test Plan:
- Good frame, NUM_CH=4: FFFFFFFF, 00000102, 00A00000, 00000400, 00000001, csum 00A00503 → one cycle after csum: f_word ch2=00A00000, p_word ch2=400, wave ch2=1, ch_en[2]=1, cfg_update=4'b0100; other channels remain 0.
- Same frame with csum 00000000 → frame_err pulse, err_code=1, channel 2 outputs unchanged, busy=0.
- Header 00000107 → frame_err and err_code=2 right after the header; the following words are ignored until the next FFFFFFFF.
- Stall of 1024 cycles after the FREQ word with TIMEOUT=1024 → frame_err, err_code=3. A good frame sent afterwards commits normally.
- Frequency word FFFFFFFF inside a frame (header 00000100, phase 0, wave 0, csum FFFFFEFF) → channel 0 f_word=FFFFFFFF and commits; no resync.
- dds_work_flag dropped mid-frame → ch_en=0 two cycles later, no frame_err, registers retained. Raising it again restores ch_en to the prior en_reg.

Source files
------------

// File: rtl/dds_conf_pkg.sv
// Shared constants for the DDS configuration decoder.
//   state_t     : frame decoder FSM states (3-bit encoding)
//   ERR_*       : err_code values reported on a discarded frame
//   HDR_*       : field positions inside the header word
package dds_conf_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_FREQ  = 3'd2,
    S_PHASE = 3'd3,
    S_WAVE  = 3'd4,
    S_CSUM  = 3'd5
  } state_t;

  localparam logic [1:0] ERR_CSUM = 2'd1;
  localparam logic [1:0] ERR_CH   = 2'd2;
  localparam logic [1:0] ERR_TO   = 2'd3;

  localparam int HDR_CH_LSB = 0;
  localparam int HDR_CH_W   = 4;
  localparam int HDR_EN_BIT = 8;

endpackage

// File: rtl/dds_ch_regs.sv
// Output register bank for one DDS channel.
//   axi_clk, rst : clock, asynchronous active-low reset
//   wr_en        : load all fields at once (atomic frame commit)
//   f_in/p_in/w_in/en_in  : staged frequency, phase, wave, enable
//   f_out/p_out/w_out/en_out : registered channel settings
module dds_ch_regs #(
  parameter int PW = 12
) (
  input  logic          axi_clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [31:0]   f_in,
  input  logic [PW-1:0] p_in,
  input  logic [1:0]    w_in,
  input  logic          en_in,
  output logic [31:0]   f_out,
  output logic [PW-1:0] p_out,
  output logic [1:0]    w_out,
  output logic          en_out
);

  always_ff @(posedge axi_clk or negedge rst) begin
    if (!rst) begin
      f_out  <= '0;
      p_out  <= '0;
      w_out  <= '0;
      en_out <= 1'b0;
    end else if (wr_en) begin
      f_out  <= f_in;
      p_out  <= p_in;
      w_out  <= w_in;
      en_out <= en_in;
    end
  end

endmodule

// File: rtl/dds_multi_conf_decoder.sv
// Framed configuration decoder for NUM_CH DDS channels.
// Frame: SYNC, header{en@8, ch@3:0}, freq, phase, wave, XOR checksum.
// A frame commits to its channel only on a checksum match.
//   axi_clk, rst      : clock, asynchronous active-low reset
//   conf_data/valid   : one 32-bit word per valid strobe
//   dds_work_flag     : global run enable (registered to dds_en)
//   f_word/p_word/wave_type/ch_en : per-channel outputs
//   cfg_update        : one-cycle pulse on the committed channel
//   frame_err/err_code: discard pulse and sticky cause
//   busy              : decoder is inside a frame
module dds_multi_conf_decoder
  import dds_conf_pkg::*;
#(
  parameter int          NUM_CH     = 4,
  parameter int          PW         = 12,
  parameter logic [31:0] FRAME_SYNC = 32'hFFFF_FFFF,
  parameter int          TIMEOUT    = 1024
) (
  input  logic                 axi_clk,
  input  logic                 rst,
  input  logic [31:0]          conf_data,
  input  logic                 conf_valid,
  input  logic                 dds_work_flag,
  output logic [NUM_CH*32-1:0] f_word,
  output logic [NUM_CH*PW-1:0] p_word,
  output logic [NUM_CH*2-1:0]  wave_type,
  output logic [NUM_CH-1:0]    ch_en,
  output logic [NUM_CH-1:0]    cfg_update,
  output logic                 frame_err,
  output logic [1:0]           err_code,
  output logic                 busy
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  state_t                state_reg, state_next;
  logic                  dds_en;
  logic [HDR_CH_W-1:0]   ch_idx_reg;
  logic                  en_bit_reg;
  logic [31:0]           tmp_f_reg;
  logic [PW-1:0]         tmp_p_reg;
  logic [1:0]            tmp_w_reg;
  logic [31:0]           csum_reg;
  logic [TO_W-1:0]       to_cnt_reg;
  logic [NUM_CH-1:0]     cfg_update_reg;
  logic                  frame_err_reg;
  logic [1:0]            err_code_reg;
  logic [NUM_CH-1:0]     en_reg;
  logic [NUM_CH-1:0]     wr_vec;

  logic                  accept;
  logic                  commit;
  logic                  err_fire;
  logic [1:0]            err_val;
  logic                  cnt_clr;
  logic                  cnt_inc;

  // Words only count while the DDS is running.
  assign accept = conf_valid && dds_en;

  always_ff @(posedge axi_clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    commit     = 1'b0;
    err_fire   = 1'b0;
    err_val    = ERR_CSUM;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    if (state_reg != S_IDLE && !dds_en) begin
      // Silent abort: the DDS was stopped under us.
      state_next = S_IDLE;
      cnt_clr    = 1'b1;
    end else if (state_reg != S_IDLE && !conf_valid) begin
      if (to_cnt_reg == TO_W'(TIMEOUT - 1)) begin
        state_next = S_IDLE;
        err_fire   = 1'b1;
        err_val    = ERR_TO;
        cnt_clr    = 1'b1;
      end else begin
        cnt_inc = 1'b1;
      end
    end else if (accept) begin
      cnt_clr = 1'b1;
      case (state_reg)
        S_IDLE: begin
          if (conf_data == FRAME_SYNC) state_next = S_HDR;
        end
        S_HDR: begin
          if ({28'd0, conf_data[HDR_CH_LSB +: HDR_CH_W]} >= 32'(NUM_CH)) begin
            state_next = S_IDLE;
            err_fire   = 1'b1;
            err_val    = ERR_CH;
          end else begin
            state_next = S_FREQ;
          end
        end
        S_FREQ:  state_next = S_PHASE;
        S_PHASE: state_next = S_WAVE;
        S_WAVE:  state_next = S_CSUM;
        S_CSUM: begin
          state_next = S_IDLE;
          if ((csum_reg ^ conf_data) == 32'd0) begin
            commit = 1'b1;
          end else begin
            err_fire = 1'b1;
            err_val  = ERR_CSUM;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Frame staging, running checksum, timeout counter and status pulses.
  always_ff @(posedge axi_clk or negedge rst) begin
    if (!rst) begin
      dds_en         <= 1'b0;
      ch_idx_reg     <= '0;
      en_bit_reg     <= 1'b0;
      tmp_f_reg      <= '0;
      tmp_p_reg      <= '0;
      tmp_w_reg      <= '0;
      csum_reg       <= '0;
      to_cnt_reg     <= '0;
      cfg_update_reg <= '0;
      frame_err_reg  <= 1'b0;
      err_code_reg   <= '0;
    end else begin
      dds_en         <= dds_work_flag;
      cfg_update_reg <= wr_vec;
      frame_err_reg  <= err_fire;
      if (err_fire) err_code_reg <= err_val;
      if (cnt_clr) begin
        to_cnt_reg <= '0;
      end else if (cnt_inc) begin
        to_cnt_reg <= to_cnt_reg + 1'b1;
      end
      if (accept) begin
        case (state_reg)
          S_HDR: begin
            ch_idx_reg <= conf_data[HDR_CH_LSB +: HDR_CH_W];
            en_bit_reg <= conf_data[HDR_EN_BIT];
            csum_reg   <= conf_data;
          end
          S_FREQ: begin
            tmp_f_reg <= conf_data;
            csum_reg  <= csum_reg ^ conf_data;
          end
          S_PHASE: begin
            tmp_p_reg <= conf_data[PW-1:0];
            csum_reg  <= csum_reg ^ conf_data;
          end
          S_WAVE: begin
            tmp_w_reg <= conf_data[1:0];
            csum_reg  <= csum_reg ^ conf_data;
          end
          default: ;
        endcase
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    localparam logic [HDR_CH_W-1:0] CH_ID = HDR_CH_W'(gi);
    assign wr_vec[gi] = commit && (ch_idx_reg == CH_ID);

    dds_ch_regs #(.PW(PW)) u_regs (
      .axi_clk (axi_clk),
      .rst     (rst),
      .wr_en   (wr_vec[gi]),
      .f_in    (tmp_f_reg),
      .p_in    (tmp_p_reg),
      .w_in    (tmp_w_reg),
      .en_in   (en_bit_reg),
      .f_out   (f_word[32*gi +: 32]),
      .p_out   (p_word[PW*gi +: PW]),
      .w_out   (wave_type[2*gi +: 2]),
      .en_out  (en_reg[gi])
    );
  end

  assign ch_en      = en_reg & {NUM_CH{dds_en}};
  assign cfg_update = cfg_update_reg;
  assign frame_err  = frame_err_reg;
  assign err_code   = err_code_reg;
  assign busy       = (state_reg != S_IDLE);

endmodule

// File: tb/tb_dds_multi_conf_decoder.sv
// Scoreboard bench for dds_multi_conf_decoder (NUM_CH=4, PW=12, TIMEOUT=1024).
module tb_dds_multi_conf_decoder;

  localparam int          NUM_CH  = 4;
  localparam int          PW      = 12;
  localparam int          TIMEOUT = 1024;
  localparam logic [31:0] SYNC    = 32'hFFFF_FFFF;

  logic                 axi_clk = 1'b0;
  logic                 rst = 1'b0;
  logic [31:0]          conf_data = '0;
  logic                 conf_valid = 1'b0;
  logic                 dds_work_flag = 1'b1;
  logic [NUM_CH*32-1:0] f_word;
  logic [NUM_CH*PW-1:0] p_word;
  logic [NUM_CH*2-1:0]  wave_type;
  logic [NUM_CH-1:0]    ch_en;
  logic [NUM_CH-1:0]    cfg_update;
  logic                 frame_err;
  logic [1:0]           err_code;
  logic                 busy;

  dds_multi_conf_decoder #(
    .NUM_CH(NUM_CH), .PW(PW), .FRAME_SYNC(SYNC), .TIMEOUT(TIMEOUT)
  ) dut (
    .axi_clk(axi_clk), .rst(rst), .conf_data(conf_data), .conf_valid(conf_valid),
    .dds_work_flag(dds_work_flag), .f_word(f_word), .p_word(p_word),
    .wave_type(wave_type), .ch_en(ch_en), .cfg_update(cfg_update),
    .frame_err(frame_err), .err_code(err_code), .busy(busy)
  );

  always #5 axi_clk = ~axi_clk;

  int cyc = 0;
  always @(posedge axi_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int                   cyc;
    logic [NUM_CH-1:0]    upd;
    logic                 err;
    logic [1:0]           code;
    logic [NUM_CH*32-1:0] f;
    logic [NUM_CH*PW-1:0] p;
    logic [NUM_CH*2-1:0]  w;
    logic [NUM_CH-1:0]    en;
  } ev_t;

  ev_t sb[$];

  // Reference model of the channel state and sticky error code.
  logic [NUM_CH*32-1:0] m_f = '0;
  logic [NUM_CH*PW-1:0] m_p = '0;
  logic [NUM_CH*2-1:0]  m_w = '0;
  logic [NUM_CH-1:0]    m_en = '0;
  logic [1:0]           m_code = '0;

  task automatic push_ev(input int when, input logic [NUM_CH-1:0] upd, input logic err);
    ev_t e;
    e.cyc = when; e.upd = upd; e.err = err; e.code = m_code;
    e.f = m_f; e.p = m_p; e.w = m_w; e.en = m_en;
    sb.push_back(e);
  endtask

  // Monitor: every DUT event must match the oldest expected event.
  always @(negedge axi_clk) begin
    if (rst && (cfg_update != '0 || frame_err)) begin
      ev_t e;
      $display("event cyc=%0d upd=%b err=%b code=%0d", cyc, cfg_update, frame_err, err_code);
      chk("sb_pending", 128'(sb.size() > 0), 128'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("ev_cycle",   128'(cyc), 128'(e.cyc));
        chk("cfg_update", 128'(cfg_update), 128'(e.upd));
        chk("frame_err",  128'(frame_err), 128'(e.err));
        chk("err_code",   128'(err_code), 128'(e.code));
        chk("f_word",     128'(f_word), 128'(e.f));
        chk("p_word",     128'(p_word), 128'(e.p));
        chk("wave_type",  128'(wave_type), 128'(e.w));
        chk("ch_en",      128'(ch_en), 128'(e.en));
        chk("busy_idle",  128'(busy), 128'd0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge axi_clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [31:0] d);
    conf_data  = d;
    conf_valid = 1'b1;
    @(posedge axi_clk);
    #1;
    conf_valid = 1'b0;
  endtask

  // Drives one full frame and records the outcome the decoder must produce.
  task automatic send_frame(input logic [31:0] hdr, input logic [31:0] f,
                            input logic [31:0] p, input logic [31:0] w,
                            input logic [31:0] cs);
    int ch;
    ch = int'(hdr[3:0]);
    $display("frame hdr=%h f=%h p=%h w=%h cs=%h", hdr, f, p, w, cs);
    send_word(SYNC);
    if (ch >= NUM_CH) begin
      m_code = 2'd2;
      push_ev(cyc + 1, '0, 1'b1);
      send_word(hdr);
    end else begin
      send_word(hdr);
    end
    send_word(f);
    send_word(p);
    send_word(w);
    if (ch < NUM_CH) begin
      if (cs == (hdr ^ f ^ p ^ w)) begin
        m_f[32*ch +: 32] = f;
        m_p[PW*ch +: PW] = p[PW-1:0];
        m_w[2*ch +: 2]   = w[1:0];
        m_en[ch]         = hdr[8];
        push_ev(cyc + 1, NUM_CH'(1 << ch), 1'b0);
      end else begin
        m_code = 2'd1;
        push_ev(cyc + 1, '0, 1'b1);
      end
    end
    send_word(cs);
    idle(2);
  endtask

  initial begin
    logic [31:0] rf, rp, rw, rh, rc;
    int k;

    // Reset state.
    idle(3);
    chk("rst_f_word", 128'(f_word), 128'd0);
    chk("rst_p_word", 128'(p_word), 128'd0);
    chk("rst_wave", 128'(wave_type), 128'd0);
    chk("rst_status", 128'({cfg_update, frame_err, err_code, ch_en, busy}), 128'd0);
    @(negedge axi_clk) rst = 1'b1;
    idle(3);
    chk("post_rst_busy", 128'(busy), 128'd0);

    // Good frame to channel 2, then the same frame with a bad checksum.
    send_frame(32'h0000_0102, 32'h00A0_0000, 32'h0000_0400, 32'h0000_0001, 32'h00A0_0503);
    send_frame(32'h0000_0102, 32'h00A0_0000, 32'h0000_0400, 32'h0000_0001, 32'h0000_0000);
    // Illegal channel; trailing words ignored.
    send_frame(32'h0000_0107, 32'h1234_5678, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000);
    // All-ones frequency word inside a frame is data.
    send_frame(32'h0000_0100, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FEFF);

    // Timeout: stall after the frequency word.
    send_word(SYNC);
    send_word(32'h0000_0101);
    send_word(32'h0000_5555);
    m_code = 2'd3;
    push_ev(cyc + TIMEOUT, '0, 1'b1);
    idle(TIMEOUT + 8);
    chk("to_busy", 128'(busy), 128'd0);
    send_frame(32'h0000_0101, 32'h0BAD_CAFE, 32'h0000_0ABC, 32'h0000_0003,
               32'h0000_0101 ^ 32'h0BAD_CAFE ^ 32'h0000_0ABC ^ 32'h0000_0003);

    // Random frames, some with illegal channels or corrupted checksums.
    for (k = 0; k < 6; k++) begin
      rh = {23'd0, 1'($urandom_range(0, 1)), 4'd0, 4'($urandom_range(0, 5))};
      rf = $urandom & 32'hFFFF_FFFE;
      rp = $urandom & 32'hFFFF_FFFE;
      rw = $urandom & 32'hFFFF_FFFE;
      rc = rh ^ rf ^ rp ^ rw;
      if ($urandom_range(0, 3) == 0) rc = rc ^ 32'h0000_0010;
      send_frame(rh, rf, rp, rw, rc);
    end

    // Run flag dropped mid-frame: silent abort, outputs retained.
    send_word(SYNC);
    send_word(32'h0000_0103);
    dds_work_flag = 1'b0;
    idle(2);
    chk("drop_ch_en", 128'(ch_en), 128'd0);
    chk("drop_busy", 128'(busy), 128'd0);
    chk("drop_f_kept", 128'(f_word), 128'(m_f));
    // A complete frame while stopped is ignored.
    send_word(SYNC);
    send_word(32'h0000_0103);
    send_word(32'h7777_7777);
    send_word(32'h0);
    send_word(32'h0);
    send_word(32'h0000_0103 ^ 32'h7777_7777);
    idle(2);
    chk("stopped_f_kept", 128'(f_word), 128'(m_f));
    dds_work_flag = 1'b1;
    idle(2);
    chk("resume_ch_en", 128'(ch_en), 128'(m_en));

    // Asynchronous reset mid-frame.
    send_word(SYNC);
    send_word(32'h0000_0100);
    #2 rst = 1'b0;
    #1;
    chk("arst_f_word", 128'(f_word), 128'd0);
    chk("arst_status", 128'({err_code, ch_en, busy}), 128'd0);
    m_f = '0; m_p = '0; m_w = '0; m_en = '0; m_code = '0;
    @(negedge axi_clk) rst = 1'b1;
    idle(3);
    send_frame(32'h0000_0103, 32'h0000_0042, 32'h0000_0123, 32'h0000_0002,
               32'h0000_0103 ^ 32'h0000_0042 ^ 32'h0000_0123 ^ 32'h0000_0002);

    idle(5);
    chk("sb_drained", 128'(sb.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
